// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - flit encodings, port indices and west-first route function
package router_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_TAIL      = 2'b01,
        FLIT_HEAD      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_t;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_EAST  = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    // Field positions counted down from the flit MSB; dest_y follows dest_x.
    localparam int TYPE_WIDTH    = 2;
    localparam int DEST_X_OFFSET = TYPE_WIDTH;

    // Coordinates are zero-extended to this width before routing.
    localparam int MAX_COORD_WIDTH = 8;

    function automatic logic [NUM_PORTS-1:0] west_first_route(
        input logic [MAX_COORD_WIDTH-1:0] cx,
        input logic [MAX_COORD_WIDTH-1:0] cy,
        input logic [MAX_COORD_WIDTH-1:0] dx,
        input logic [MAX_COORD_WIDTH-1:0] dy,
        input logic [NUM_PORTS-1:0]       congested
    );
        logic [NUM_PORTS-1:0] r;
        logic [2:0]           ydir;
        r    = '0;
        ydir = (dy > cy) ? PORT_NORTH : PORT_SOUTH;
        if (dx < cx) begin
            r[PORT_WEST] = 1'b1;
        end else if (dx == cx) begin
            if (dy == cy)     r[PORT_LOCAL] = 1'b1;
            else              r[ydir]       = 1'b1;
        end else if (dy == cy) begin
            r[PORT_EAST] = 1'b1;
        end else if (!congested[PORT_EAST]) begin
            r[PORT_EAST] = 1'b1;
        end else if (!congested[ydir]) begin
            r[ydir] = 1'b1;
        end else begin
            // Both productive ports busy: stay on the X leg.
            r[PORT_EAST] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/route_compute.sv
// rtl/route_compute.sv - per-input route computation with wormhole lock
module route_compute
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int COORD_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COORD_WIDTH-1:0] cur_x,
    input  logic [COORD_WIDTH-1:0] cur_y,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    output logic                   fifo_pop,
    input  logic [NUM_PORTS-1:0]   congested,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_flit,
    output logic [NUM_PORTS-1:0]   out_port,
    output logic                   err,
    output logic [CNT_WIDTH-1:0]   pkt_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   route_q, route_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;

    flit_type_t             head_type;
    logic [COORD_WIDTH-1:0] dest_x, dest_y;
    logic                   is_head, is_tail;

    assign head_type = flit_type_t'(fifo_dout[DATA_WIDTH-1 -: TYPE_WIDTH]);
    assign dest_x    = fifo_dout[DATA_WIDTH-1-DEST_X_OFFSET -: COORD_WIDTH];
    assign dest_y    = fifo_dout[DATA_WIDTH-1-DEST_X_OFFSET-COORD_WIDTH -: COORD_WIDTH];
    assign is_head   = (head_type == FLIT_HEAD) || (head_type == FLIT_HEAD_TAIL);
    assign is_tail   = (head_type == FLIT_TAIL) || (head_type == FLIT_HEAD_TAIL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            route_q     <= '0;
            err_q       <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            err_q       <= err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        err_d       = err_q;
        pkt_count_d = pkt_count_q;
        out_valid   = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (is_head) begin
                        route_d = west_first_route(MAX_COORD_WIDTH'(cur_x), MAX_COORD_WIDTH'(cur_y),
                                                   MAX_COORD_WIDTH'(dest_x), MAX_COORD_WIDTH'(dest_y),
                                                   congested);
                        state_d = SEND;
                    end else begin
                        // Orphan body/tail: discard it so the fifo cannot wedge.
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            SEND: begin
                out_valid = !fifo_empty;
                fifo_pop  = out_valid && out_ready;
                if (fifo_pop && is_tail) begin
                    pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_flit  = fifo_dout;
    assign out_port  = route_q;
    assign err       = err_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_route_compute.sv
// tb/tb_route_compute.sv - randomized self-checking bench for route_compute
module tb_route_compute;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cur_x, cur_y;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        fifo_pop;
    logic [4:0]  congested;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_flit;
    logic [4:0]  out_port;
    logic        err;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    route_compute dut (
        .clk        (clk),
        .reset      (reset),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .congested  (congested),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flit   (out_flit),
        .out_port   (out_port),
        .err        (err),
        .pkt_count  (pkt_count)
    );

    logic [63:0] fq[$];
    logic        m_busy;
    logic        m_err;
    logic [15:0] m_pkt;
    logic [4:0]  m_route;
    logic [4:0]  last_port;
    logic        cong_rand = 1'b0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          n_xfer    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Mesh routing from signed hop counts: any westward hop goes first.
    function automatic logic [4:0] ref_route(input int cx, input int cy, input int dx, input int dy,
                                             input logic [4:0] cg);
        int hx, hy;
        hx = dx - cx;
        hy = dy - cy;
        if (hx < 0) return 5'b10000;
        if (hx == 0) begin
            if (hy == 0) return 5'b00001;
            return (hy > 0) ? 5'b00010 : 5'b01000;
        end
        if (hy == 0 || !cg[2]) return 5'b00100;
        if (hy > 0) return cg[1] ? 5'b00100 : 5'b00010;
        return cg[3] ? 5'b00100 : 5'b01000;
    endfunction

    function automatic logic [63:0] mk_flit(input logic [1:0] t, input int dx, input int dy);
        return {t, 3'(dx), 3'(dy), 32'($urandom), 24'($urandom)};
    endfunction

    task automatic push_packet(input int dx, input int dy, input int len);
        if (len == 1) begin
            fq.push_back(mk_flit(2'b11, dx, dy));
        end else begin
            fq.push_back(mk_flit(2'b10, dx, dy));
            for (int i = 0; i < len - 2; i++)
                fq.push_back(mk_flit(($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                                     $urandom_range(0, 7), $urandom_range(0, 7)));
            fq.push_back(mk_flit(2'b01, $urandom_range(0, 7), $urandom_range(0, 7)));
        end
    endtask

    task automatic run_cycle(input logic rdy);
        logic       exp_valid, exp_pop, route_now, done_pkt;
        logic [1:0] ftype;
        @(negedge clk);
        out_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? 64'd0 : fq[0];
        if (cong_rand) congested = 5'($urandom);
        #1;
        exp_valid = 1'b0;
        exp_pop   = 1'b0;
        route_now = 1'b0;
        done_pkt  = 1'b0;
        ftype     = fifo_dout[63:62];
        if (!fifo_empty) begin
            if (!m_busy) begin
                if (ftype == 2'b10 || ftype == 2'b11) begin
                    route_now = 1'b1;
                    m_route   = ref_route(cur_x, cur_y, fifo_dout[61:59], fifo_dout[58:56], congested);
                end else begin
                    exp_pop = 1'b1;
                end
            end else begin
                exp_valid = 1'b1;
                exp_pop   = rdy;
                done_pkt  = rdy && (ftype == 2'b01 || ftype == 2'b11);
            end
        end
        check("out_valid", out_valid, exp_valid);
        check("fifo_pop", fifo_pop, exp_pop);
        check("err", err, m_err);
        check("pkt_count", pkt_count, m_pkt);
        if (exp_valid) begin
            check("out_flit", out_flit, fifo_dout);
            check("out_port", out_port, m_route);
        end
        if (exp_valid && rdy) begin
            n_xfer++;
            last_port = out_port;
        end
        if (route_now) m_busy = 1'b1;
        if (!m_busy && exp_pop) m_err = 1'b1;
        if (done_pkt) begin
            m_busy = 1'b0;
            m_pkt++;
        end
        if (exp_pop) void'(fq.pop_front());
    endtask

    task automatic do_reset(input int cx, input int cy);
        @(negedge clk);
        reset      = 1'b1;
        cur_x      = 3'(cx);
        cur_y      = 3'(cy);
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        out_ready  = 1'b0;
        fq.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_pop", fifo_pop, 1'b0);
        check("rst_port", out_port, 5'b00000);
        check("rst_err", err, 1'b0);
        check("rst_pkt", pkt_count, 16'd0);
        reset  = 1'b0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_pkt  = '0;
    endtask

    task automatic drain(input int budget, input logic rand_ready);
        for (int i = 0; i < budget && (fq.size() != 0 || m_busy); i++)
            run_cycle(rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        check("drain_done", (fq.size() == 0) && !m_busy, 1'b1);
    endtask

    initial begin
        logic [4:0] cong_set [3];
        logic [4:0] port_exp [3];
        reset     = 1'b1;
        congested = '0;
        m_route   = '0;
        last_port = '0;
        cong_set  = '{5'b00000, 5'b00100, 5'b01100};
        port_exp  = '{5'b00100, 5'b01000, 5'b00100};

        do_reset(3, 3);

        congested = 5'b10000;
        push_packet(1, 5, 3);
        n_xfer = 0;
        for (int i = 0; i < 5; i++) run_cycle(1'b1);
        check("west_xfers", n_xfer, 3);
        check("west_port", last_port, 5'b10000);
        check("west_pkt", pkt_count, 16'd1);

        for (int i = 0; i < 3; i++) begin
            congested = cong_set[i];
            push_packet(5, 1, 1);
            drain(50, 1'b0);
            check("adaptive_port", last_port, port_exp[i]);
        end

        congested = '0;
        push_packet(3, 3, 1);
        drain(50, 1'b0);
        check("local_port", last_port, 5'b00001);
        push_packet(3, 6, 1);
        drain(50, 1'b0);
        check("north_port", last_port, 5'b00010);

        push_packet(6, 6, 4);
        n_xfer = 0;
        run_cycle(1'b1);
        run_cycle(1'b1);
        for (int i = 0; i < 4; i++) run_cycle(1'b0);
        check("stall_xfers", n_xfer, 1);
        drain(50, 1'b0);
        check("stall_total", n_xfer, 4);
        check("stall_port", last_port, 5'b00100);

        fq.push_back(mk_flit(2'b00, 0, 0));
        push_packet(3, 6, 1);
        drain(50, 1'b0);
        check("orphan_err", err, 1'b1);
        check("orphan_port", last_port, 5'b00010);
        run_cycle(1'b1);
        check("err_sticky", err, 1'b1);

        for (int ep = 0; ep < 3; ep++) begin
            do_reset($urandom_range(0, 7), $urandom_range(0, 7));
            cong_rand = 1'b1;
            for (int p = 0; p < 12; p++) begin
                if ($urandom_range(0, 9) == 0) fq.push_back(mk_flit(2'b01, 0, 0));
                push_packet($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 5));
            end
            drain(3000, 1'b1);
            push_packet($urandom_range(0, 7), $urandom_range(0, 7), 5);
            for (int i = 0; i < 3; i++) run_cycle(1'b1);
            cong_rand = 1'b0;
        end
        do_reset(2, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
